// File: rtl/hazard_unit.sv
// Hazard detection and pipeline control: load-use stalls, taken-branch flush, memory-busy freeze.
// Latency: outputs are combinational from registered state plus current inputs (Mealy), zero-cycle.
// Backpressure: mem_busy_in freezes PC and IF/ID and holds all internal state.
module hazard_unit #(
  parameter int REG_ADDR_W        = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn_in,
  input  logic                  id_rn_valid_in,
  input  logic [REG_ADDR_W-1:0] id_rm_in,
  input  logic                  id_rm_valid_in,
  input  logic [REG_ADDR_W-1:0] ex_rd_in,
  input  logic                  ex_mem_read_in,
  input  logic                  branch_taken_in,
  input  logic                  mem_busy_in,
  output logic                  pc_write_enable_out,
  output logic                  if_id_write_enable_out,
  output logic                  if_id_flush_out,
  output logic                  nop_select_out,
  output logic [1:0]            hazard_state_out,
  output logic [CNT_W-1:0]      stall_cycles_out
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [3:0]       STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state;
  logic [3:0] stall_cnt;
  logic       load_use;

  assign load_use = ex_mem_read_in &
                    ((id_rn_valid_in & (id_rn_in == ex_rd_in)) |
                     (id_rm_valid_in & (id_rm_in == ex_rd_in)));

  always_comb begin
    pc_write_enable_out    = 1'b1;
    if_id_write_enable_out = 1'b1;
    if_id_flush_out        = 1'b0;
    nop_select_out         = 1'b0;
    hazard_state_out       = state;
    if (reset) begin
      hazard_state_out = RUN;
    end else if (mem_busy_in) begin
      pc_write_enable_out    = 1'b0;
      if_id_write_enable_out = 1'b0;
    end else if (branch_taken_in && state != FLUSH) begin
      if_id_flush_out = 1'b1;
      nop_select_out  = 1'b1;
    end else if (state == STALL || (state != STALL && load_use)) begin
      pc_write_enable_out    = 1'b0;
      if_id_write_enable_out = 1'b0;
      nop_select_out         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      stall_cnt        <= 4'd0;
      stall_cycles_out <= '0;
    end else begin
      if (!pc_write_enable_out && stall_cycles_out != CNT_MAX)
        stall_cycles_out <= stall_cycles_out + 1'b1;
      if (!mem_busy_in) begin
        case (state)
          STALL: begin
            if (branch_taken_in) begin
              state     <= FLUSH;
              stall_cnt <= 4'd0;
            end else if (stall_cnt == 4'd1) begin
              state     <= RUN;
              stall_cnt <= 4'd0;
            end else begin
              stall_cnt <= stall_cnt - 4'd1;
            end
          end
          default: begin
            // FLUSH evaluates load-use exactly like RUN; the bubble in EX cannot carry a branch
            if (branch_taken_in && state == RUN) begin
              state <= FLUSH;
            end else if (load_use && LOAD_STALL_CYCLES > 1) begin
              state     <= STALL;
              stall_cnt <= STALL_INIT;
            end else begin
              state <= RUN;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (1-cycle load stall, 3-cycle stall, 4-bit counter) share stimulus.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, ex_rd;
  logic       id_rn_valid, id_rm_valid, ex_mem_read, branch_taken, mem_busy;

  logic        a_pc, a_ifid, a_flush, a_nop;
  logic [1:0]  a_state;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_flush, b_nop;
  logic [1:0]  b_state;
  logic [15:0] b_cnt;
  logic        c_pc, c_ifid, c_flush, c_nop;
  logic [1:0]  c_state;
  logic [3:0]  c_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .id_rn_in(id_rn), .id_rn_valid_in(id_rn_valid), .id_rm_in(id_rm), .id_rm_valid_in(id_rm_valid),
    .ex_rd_in(ex_rd), .ex_mem_read_in(ex_mem_read), .branch_taken_in(branch_taken), .mem_busy_in(mem_busy),
    .pc_write_enable_out(a_pc), .if_id_write_enable_out(a_ifid), .if_id_flush_out(a_flush),
    .nop_select_out(a_nop), .hazard_state_out(a_state), .stall_cycles_out(a_cnt));

  hazard_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset),
    .id_rn_in(id_rn), .id_rn_valid_in(id_rn_valid), .id_rm_in(id_rm), .id_rm_valid_in(id_rm_valid),
    .ex_rd_in(ex_rd), .ex_mem_read_in(ex_mem_read), .branch_taken_in(branch_taken), .mem_busy_in(mem_busy),
    .pc_write_enable_out(b_pc), .if_id_write_enable_out(b_ifid), .if_id_flush_out(b_flush),
    .nop_select_out(b_nop), .hazard_state_out(b_state), .stall_cycles_out(b_cnt));

  hazard_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset),
    .id_rn_in(id_rn), .id_rn_valid_in(id_rn_valid), .id_rm_in(id_rm), .id_rm_valid_in(id_rm_valid),
    .ex_rd_in(ex_rd), .ex_mem_read_in(ex_mem_read), .branch_taken_in(branch_taken), .mem_busy_in(mem_busy),
    .pc_write_enable_out(c_pc), .if_id_write_enable_out(c_ifid), .if_id_flush_out(c_flush),
    .nop_select_out(c_nop), .hazard_state_out(c_state), .stall_cycles_out(c_cnt));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pack {pc, ifid, flush, nop, state} for one-shot output comparison
  function automatic logic [15:0] pk(input logic pc, ifid, fl, nop, input logic [1:0] st);
    return {11'd0, pc, ifid, fl, nop, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 4'd0; id_rm = 4'd0; ex_rd = 4'd0;
    id_rn_valid = 1'b0; id_rm_valid = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic load_use_rn5();
    ex_mem_read = 1'b1; ex_rd = 4'd5; id_rn = 4'd5; id_rn_valid = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_outputs", pk(a_pc, a_ifid, a_flush, a_nop, a_state), pk(1, 1, 0, 0, 2'b00));
    chk("reset_count", a_cnt, 16'd0);

    // Single-cycle load-use on Rm
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rm = 4'd3; id_rm_valid = 1'b1; id_rn = 4'd7; id_rn_valid = 1'b1;
    #1;
    chk("lu1_bubble", pk(a_pc, a_ifid, a_flush, a_nop, a_state), pk(0, 0, 0, 1, 2'b00));
    tick();
    idle();
    #1;
    chk("lu1_after", pk(a_pc, a_ifid, a_flush, a_nop, a_state), pk(1, 1, 0, 0, 2'b00));
    chk("lu1_count", a_cnt, 16'd1);

    // Three-cycle load-use on Rn
    do_reset();
    load_use_rn5();
    #1;
    chk("lu3_c1", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 1, 2'b00));
    tick();
    idle();
    #1;
    chk("lu3_c2", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 1, 2'b01));
    tick();
    #1;
    chk("lu3_c3", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 1, 2'b01));
    tick();
    #1;
    chk("lu3_run", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));
    chk("lu3_count", b_cnt, 16'd3);

    load_use_rn5();
    id_rn_valid = 1'b0;
    #1;
    chk("rn_invalid", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));
    idle();
    ex_mem_read = 1'b1; ex_rd = 4'd15; id_rm = 4'd15; id_rm_valid = 1'b1;
    #1;
    chk("r15_hazard", pk(a_pc, a_ifid, a_flush, a_nop, a_state), pk(0, 0, 0, 1, 2'b00));
    idle();

    // Branch taken in RUN
    do_reset();
    branch_taken = 1'b1;
    #1;
    chk("br_cycle", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 1, 1, 2'b00));
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_flush", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b10));
    tick();
    #1;
    chk("br_run", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));

    // Memory busy freezes a stall in progress
    load_use_rn5();
    tick();
    idle();
    mem_busy = 1'b1;
    #1;
    chk("busy_1", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 0, 2'b01));
    tick();
    #1;
    chk("busy_2", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 0, 2'b01));
    tick();
    mem_busy = 1'b0;
    #1;
    chk("busy_resume", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 1, 2'b01));
    tick();
    #1;
    chk("busy_last", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(0, 0, 0, 1, 2'b01));
    tick();
    #1;
    chk("busy_done", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));

    // Branch abandons a stall
    load_use_rn5();
    tick();
    idle();
    branch_taken = 1'b1;
    #1;
    chk("stall_br", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 1, 1, 2'b01));
    tick();
    branch_taken = 1'b0;
    #1;
    chk("stall_br_flush", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b10));
    tick();
    #1;
    chk("stall_br_run", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));

    // Reset in the middle of a stall
    load_use_rn5();
    tick();
    idle();
    reset = 1'b1;
    #1;
    chk("rst_forced", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));
    tick();
    reset = 1'b0;
    #1;
    chk("rst_run", pk(b_pc, b_ifid, b_flush, b_nop, b_state), pk(1, 1, 0, 0, 2'b00));
    chk("rst_count", b_cnt, 16'd0);

    // Counter saturation via 20 busy cycles
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    mem_busy = 1'b0;
    #1;
    chk("sat_c", {12'd0, c_cnt}, 16'd15);
    chk("nosat_b", b_cnt, 16'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
